farm_sensor_conditioner: RTL and testbench
==========================================

Name: farm_sensor_conditioner

Overview:
- Upstream stage of the highway/farm-road traffic light controller; produces its farm-road car-waiting input `c`.
- Conditions the raw, asynchronous farm-road loop-detector signal: synchronize, debounce, then edge-detect.
- Keeps a saturating count of waiting vehicles and drains it while the controller shows farm green (`fg`).
- `c` stays high while any vehicle is queued, so the controller holds farm green until the queue empties or the long timer expires.

Parameters:
- DB_CYCLES, 8, consecutive synchronized samples that must disagree with the debounced level before it flips (legal range 2..2**DB_W-1).
- DB_W, 4, debounce counter width.
- Q_W, 4, vehicle-count width; count saturates at 2**Q_W-1.
- DRAIN_CYCLES, 16, farm-green cycles credited per departing vehicle (legal range 2..2**DR_W-1).
- DR_W, 5, drain counter width.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset; one clock, reset is asynchronous and active-low.
- sens_raw  in  1  raw loop detector; asynchronous to clk and may bounce.
- fg  in  1  farm-road green from the controller.
- c  out  1  vehicle waiting; equals (car_cnt != 0), decoded combinationally from the car_cnt register.
- car_cnt  out  Q_W  vehicles queued.
- arrive_pulse  out  1  registered one-cycle strobe per debounced arrival.
- overflow  out  1  sticky; set when an arrival is dropped at saturation.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Synchronizer flops, debounce FSM (LOW_STABLE), both counters, car_cnt, arrive_pulse and overflow all clear immediately.
  - c=0.
  - A reset asserted mid-operation discards any pending confirmation or drain progress.
- Synchronizer: 2 flops on sens_raw; the debounce logic samples only the second flop (sync).
- Debounce FSM, states LOW_STABLE, CONFIRM_HIGH, HIGH_STABLE, CONFIRM_LOW:
  - LOW_STABLE: sync=1 -> CONFIRM_HIGH with db_cnt=1; otherwise stay.
  - CONFIRM_HIGH:
    - sync=0 -> LOW_STABLE, db_cnt=0.
    - sync=1 and db_cnt=DB_CYCLES-1 -> HIGH_STABLE, db_cnt=0, arrive_pulse=1 on that same edge.
    - Otherwise db_cnt+1.
  - HIGH_STABLE / CONFIRM_LOW: mirror of the above with the opposite polarity; the falling transition generates no pulse.
  - Debounced level = 1 in HIGH_STABLE and CONFIRM_LOW.
- Debounce latency: a clean raw rising edge produces arrive_pulse 2+DB_CYCLES rising edges after the first sampling edge. Any disagreeing sample restarts confirmation.
- arrive_pulse: high exactly one cycle per LOW->HIGH debounced transition; 0 otherwise.
- Drain counter dr_cnt:
  - Increments while fg=1 and car_cnt!=0.
  - When fg=1, car_cnt!=0 and dr_cnt=DRAIN_CYCLES-1: assert dec, dr_cnt=0.
  - fg=0 or car_cnt=0: dr_cnt=0 (partial progress discarded).
- car_cnt update (registered; effective the cycle after the qualifying edge):
  - arrive only: +1.
  - dec only: -1.
  - arrive and dec together: unchanged.
  - arrive at 2**Q_W-1 with no dec: hold, set overflow.
  - Underflow cannot occur, because dec requires car_cnt!=0.
- overflow: cleared only by reset.
- c falls in the same cycle car_cnt reaches 0; no extra latency.

Decomposition:
- Shared package (traffic pkg):
  - Debounce state encoding: 2-bit, LOW_STABLE=00, CONFIRM_HIGH=01, HIGH_STABLE=10, CONFIRM_LOW=11.
  - Default DB_CYCLES and DRAIN_CYCLES constants, shared with the controller's timer modules.
- Sub-module sens_debounce: synchronizer, debounce FSM and db_cnt.
  - Inputs: clk, rst_n, sens_raw.
  - Outputs: db_level, rise_pulse.
- Top level holds the drain counter, car_cnt, overflow and the c decode.

Test Plan:
- Reset: preload car_cnt=3 via arrivals, overflow=1, then pulse rst_n low for 1 cycle mid-drain -> all outputs 0 immediately, FSM in LOW_STABLE.
- Clean arrival: sens_raw 0->1 held 20 cycles, fg=0 -> arrive_pulse exactly once, 10 edges after the first sampling edge; car_cnt=1 and c=1 the next cycle; release gives no second pulse.
- Glitch reject: sens_raw high for 5 cycles, then low -> no arrive_pulse, car_cnt stays 0.
- Bounce: sens_raw toggling every 3 cycles for 30 cycles, then steady high 20 cycles -> exactly one arrive_pulse, car_cnt=1.
- Drain: car_cnt=2, fg=1 held 40 cycles -> car_cnt=1 after edge 16, 0 after edge 32, c falls with it. Repeat with fg dropped at cycle 10 and re-raised -> first decrement only 16 cycles after re-raise.
- Saturation and simultaneity:
  - 17 debounced arrivals with fg=0 -> car_cnt=15, overflow=1.
  - Arrival coinciding with a dec at car_cnt=5 -> car_cnt stays 5.

Source files
------------

// File: rtl/farm_sensor_conditioner_pkg.sv
// rtl/farm_sensor_conditioner_pkg.sv - shared types and default timing constants
// Debounce state encoding and default cycle counts shared with the controller's timers.
package farm_sensor_conditioner_pkg;

   typedef enum logic [1:0] {
      LOW_STABLE   = 2'b00,
      CONFIRM_HIGH = 2'b01,
      HIGH_STABLE  = 2'b10,
      CONFIRM_LOW  = 2'b11
   } db_state_e;

   localparam int DB_CYCLES_DEF    = 8;
   localparam int DB_W_DEF         = 4;
   localparam int Q_W_DEF          = 4;
   localparam int DRAIN_CYCLES_DEF = 16;
   localparam int DR_W_DEF         = 5;

endpackage

// File: rtl/farm_sensor_conditioner_sens_debounce.sv
// rtl/farm_sensor_conditioner_sens_debounce.sv - loop detector synchronizer and debounce FSM
// Emits a registered one-cycle rise_pulse on each confirmed low-to-high transition.
module sens_debounce
   import farm_sensor_conditioner_pkg::*;
#(
   parameter int DB_CYCLES = DB_CYCLES_DEF,
   parameter int DB_W      = DB_W_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sens_raw,
   output logic db_level,
   output logic rise_pulse
);

   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
   localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

   logic            sync1_q, sync1_d;
   logic            sync2_q, sync2_d;
   db_state_e       state_q, state_d;
   logic [DB_W-1:0] db_cnt_q, db_cnt_d;
   logic            rise_q, rise_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         state_q  <= LOW_STABLE;
         db_cnt_q <= '0;
         rise_q   <= 1'b0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         state_q  <= state_d;
         db_cnt_q <= db_cnt_d;
         rise_q   <= rise_d;
      end
   end

   // Any sample agreeing with the current stable level aborts confirmation.
   always_comb begin
      sync1_d  = sens_raw;
      sync2_d  = sync1_q;
      state_d  = state_q;
      db_cnt_d = db_cnt_q;
      case (state_q)
         LOW_STABLE: begin
            if (sync2_q) begin
               state_d  = CONFIRM_HIGH;
               db_cnt_d = DB_ONE;
            end
         end
         CONFIRM_HIGH: begin
            if (!sync2_q) begin
               state_d  = LOW_STABLE;
               db_cnt_d = '0;
            end else if (db_cnt_q == DB_LAST) begin
               state_d  = HIGH_STABLE;
               db_cnt_d = '0;
            end else begin
               db_cnt_d = db_cnt_q + DB_ONE;
            end
         end
         HIGH_STABLE: begin
            if (!sync2_q) begin
               state_d  = CONFIRM_LOW;
               db_cnt_d = DB_ONE;
            end
         end
         CONFIRM_LOW: begin
            if (sync2_q) begin
               state_d  = HIGH_STABLE;
               db_cnt_d = '0;
            end else if (db_cnt_q == DB_LAST) begin
               state_d  = LOW_STABLE;
               db_cnt_d = '0;
            end else begin
               db_cnt_d = db_cnt_q + DB_ONE;
            end
         end
         default: begin
            state_d  = LOW_STABLE;
            db_cnt_d = '0;
         end
      endcase
   end

   always_comb begin
      db_level = (state_q == HIGH_STABLE) || (state_q == CONFIRM_LOW);
      rise_d   = (state_q == CONFIRM_HIGH) && sync2_q && (db_cnt_q == DB_LAST);
   end

   assign rise_pulse = rise_q;

endmodule

// File: rtl/farm_sensor_conditioner.sv
// rtl/farm_sensor_conditioner.sv - farm-road vehicle queue feeding the light controller's c input
// Counts debounced arrivals and drains one vehicle per DRAIN_CYCLES of farm green.
module farm_sensor_conditioner
   import farm_sensor_conditioner_pkg::*;
#(
   parameter int DB_CYCLES    = DB_CYCLES_DEF,
   parameter int DB_W         = DB_W_DEF,
   parameter int Q_W          = Q_W_DEF,
   parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
   parameter int DR_W         = DR_W_DEF
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           sens_raw,
   input  logic           fg,
   output logic           c,
   output logic [Q_W-1:0] car_cnt,
   output logic           arrive_pulse,
   output logic           overflow
);

   localparam logic [Q_W-1:0]  Q_MAX   = {Q_W{1'b1}};
   localparam logic [Q_W-1:0]  Q_ONE   = Q_W'(1);
   localparam logic [DR_W-1:0] DR_LAST = DR_W'(DRAIN_CYCLES - 1);
   localparam logic [DR_W-1:0] DR_ONE  = DR_W'(1);

   logic            db_level;
   logic            arrive;
   logic            dec;
   logic [DR_W-1:0] dr_cnt_q, dr_cnt_d;
   logic [Q_W-1:0]  car_cnt_q, car_cnt_d;
   logic            overflow_q, overflow_d;

   sens_debounce #(
      .DB_CYCLES (DB_CYCLES),
      .DB_W      (DB_W)
   ) u_deb (
      .clk        (clk),
      .rst_n      (rst_n),
      .sens_raw   (sens_raw),
      .db_level   (db_level),
      .rise_pulse (arrive_pulse)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dr_cnt_q   <= '0;
         car_cnt_q  <= '0;
         overflow_q <= 1'b0;
      end else begin
         dr_cnt_q   <= dr_cnt_d;
         car_cnt_q  <= car_cnt_d;
         overflow_q <= overflow_d;
      end
   end

   // The pulse only ever fires on entry to HIGH_STABLE, so db_level is high alongside it.
   always_comb begin
      arrive     = arrive_pulse && db_level;
      dec        = fg && (car_cnt_q != '0) && (dr_cnt_q == DR_LAST);
      dr_cnt_d   = '0;
      car_cnt_d  = car_cnt_q;
      overflow_d = overflow_q;
      if (fg && (car_cnt_q != '0) && !dec) begin
         dr_cnt_d = dr_cnt_q + DR_ONE;
      end
      case ({arrive, dec})
         2'b10: begin
            if (car_cnt_q == Q_MAX) begin
               overflow_d = 1'b1;
            end else begin
               car_cnt_d = car_cnt_q + Q_ONE;
            end
         end
         2'b01:   car_cnt_d = car_cnt_q - Q_ONE;
         default: car_cnt_d = car_cnt_q;
      endcase
   end

   assign car_cnt  = car_cnt_q;
   assign overflow = overflow_q;
   assign c        = (car_cnt_q != '0);

endmodule

// File: tb/tb_farm_sensor_conditioner.sv
// tb/tb_farm_sensor_conditioner.sv - scoreboard bench for farm_sensor_conditioner
module tb_farm_sensor_conditioner;
   import farm_sensor_conditioner_pkg::*;

   localparam int DB    = 8;
   localparam int DRAIN = 16;
   localparam int QMAX  = 15;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sens_raw = 1'b0;
   logic       fg = 1'b0;
   logic       c;
   logic [3:0] car_cnt;
   logic       arrive_pulse;
   logic       overflow;

   farm_sensor_conditioner dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sens_raw     (sens_raw),
      .fg           (fg),
      .c            (c),
      .car_cnt      (car_cnt),
      .arrive_pulse (arrive_pulse),
      .overflow     (overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic arr;
      int   car;
      logic ovf;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   pulses = 0;

   // Reference model state: delayed raw samples, run length of disagreeing samples, queue counts.
   logic m_sh1, m_sh2, m_level, m_arr, m_ovf, m_s, m_dec;
   int   m_run, m_car, m_dr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s actual %0d expected %0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   task automatic model_step();
      if (!rst_n) begin
         m_sh1 = 0; m_sh2 = 0; m_level = 0; m_arr = 0; m_ovf = 0;
         m_run = 0; m_car = 0; m_dr = 0;
         exp_q.delete();
      end else begin
         m_dec = fg && (m_car != 0) && (m_dr + 1 == DRAIN);
         if (fg && (m_car != 0) && !m_dec) m_dr = m_dr + 1;
         else m_dr = 0;
         if (m_arr && !m_dec) begin
            if (m_car == QMAX) m_ovf = 1;
            else m_car = m_car + 1;
         end else if (m_dec && !m_arr) begin
            m_car = m_car - 1;
         end
         m_s   = m_sh2;
         m_sh2 = m_sh1;
         m_sh1 = sens_raw;
         m_arr = 0;
         if (m_s != m_level) begin
            m_run = m_run + 1;
            if (m_run == DB) begin
               m_level = m_s;
               m_run   = 0;
               m_arr   = m_s;
            end
         end else begin
            m_run = 0;
         end
         exp_q.push_back('{arr: m_arr, car: m_car, ovf: m_ovf});
      end
   endtask

   task automatic monitor_step();
      if (rst_n) begin
         if (arrive_pulse === 1'b1) pulses++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_arrive", 32'(arrive_pulse), 32'(e.arr));
            chk("sb_car_cnt", 32'(car_cnt), 32'(e.car));
            chk("sb_c", 32'(c), 32'(e.car != 0));
            chk("sb_overflow", 32'(overflow), 32'(e.ovf));
         end
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk or negedge rst_n) model_step();
   always @(negedge clk) monitor_step();

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic arrive_one();
      sens_raw = 1'b1; step(12);
      sens_raw = 1'b0; step(12);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0, t0, tp;
      step(2);
      chk("rst_c", 32'(c), 0);
      chk("rst_car_cnt", 32'(car_cnt), 0);
      chk("rst_arrive", 32'(arrive_pulse), 0);
      chk("rst_overflow", 32'(overflow), 0);
      rst_n = 1'b1;
      step(3);

      // clean arrival and its latency from the first sampling edge
      p0 = pulses; tp = -1;
      sens_raw = 1'b1;
      t0 = cyc + 1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (arrive_pulse === 1'b1) begin tp = cyc; break; end
      end
      chk("arrive_latency", 32'(tp - t0 + 1), 32'(2 + DB));
      step(2);
      chk("clean_car_cnt", 32'(car_cnt), 1);
      chk("clean_c", 32'(c), 1);
      step(8);
      sens_raw = 1'b0; step(20);
      chk("clean_pulse_count", 32'(pulses - p0), 1);

      // short glitch
      p0 = pulses;
      sens_raw = 1'b1; step(5);
      sens_raw = 1'b0; step(15);
      chk("glitch_pulses", 32'(pulses - p0), 0);
      chk("glitch_car_cnt", 32'(car_cnt), 1);

      // bounce then steady
      p0 = pulses;
      for (int i = 0; i < 10; i++) begin
         sens_raw = ~sens_raw; step(3);
      end
      sens_raw = 1'b1; step(20);
      sens_raw = 1'b0; step(15);
      chk("bounce_pulses", 32'(pulses - p0), 1);
      chk("bounce_car_cnt", 32'(car_cnt), 2);

      // continuous drain of two vehicles
      fg = 1'b1; step(15);
      chk("drain_e15", 32'(car_cnt), 2);
      step(1);
      chk("drain_e16", 32'(car_cnt), 1);
      step(15);
      chk("drain_e31", 32'(car_cnt), 1);
      step(1);
      chk("drain_e32", 32'(car_cnt), 0);
      chk("drain_c", 32'(c), 0);
      step(8);
      fg = 1'b0;

      // interrupted drain discards partial progress
      arrive_one(); arrive_one();
      fg = 1'b1; step(10);
      fg = 1'b0; step(3);
      fg = 1'b1; step(15);
      chk("partial_e15", 32'(car_cnt), 2);
      step(1);
      chk("partial_e16", 32'(car_cnt), 1);
      fg = 1'b0; step(2);

      // saturation
      for (int i = 0; i < 17; i++) arrive_one();
      chk("sat_car_cnt", 32'(car_cnt), QMAX);
      chk("sat_overflow", 32'(overflow), 1);

      // drain down to three, then reset mid-drain
      fg = 1'b1; step(12 * DRAIN + 5);
      chk("pre_rst_car_cnt", 32'(car_cnt), 3);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_c", 32'(c), 0);
      chk("midrst_car_cnt", 32'(car_cnt), 0);
      chk("midrst_overflow", 32'(overflow), 0);
      chk("midrst_arrive", 32'(arrive_pulse), 0);
      chk("midrst_state", 32'(dut.u_deb.state_q), 32'(LOW_STABLE));
      fg = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b1;
      step(3);

      // arrival landing on the same edge as a decrement
      for (int i = 0; i < 5; i++) arrive_one();
      chk("sim_pre_car_cnt", 32'(car_cnt), 5);
      fg = 1'b1; step(5);
      sens_raw = 1'b1;
      step(11);
      chk("sim_e16_car_cnt", 32'(car_cnt), 5);
      step(1);
      chk("sim_e17_car_cnt", 32'(car_cnt), 5);
      sens_raw = 1'b0; fg = 1'b0; step(15);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 11) == 0) sens_raw = ~sens_raw;
         if ($urandom_range(0, 39) == 0) fg = ~fg;
         step(1);
      end
      sens_raw = 1'b0; fg = 1'b0; step(20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
